data_mem_responder: RTL and testbench

Memory-side responder for CPU load/store traffic: accepts one request at a time over a valid/ready handshake, inserts a configurable number of wait states, and performs byte/half/word accesses with little-endian lane steering and load sign/zero extension. Returns the result over a second valid/ready handshake. Sits between the CPU memory stage (initiator) and a word-organised on-chip RAM. Replaces the zero-latency combinational data memory once the pipeline gains stall support.

---
 rtl/dmem_pkg.sv | 32 +++
 rtl/mem_lane_align.sv | 45 ++++
 rtl/data_mem_responder.sv | 139 +++++++++++++
 tb/tb_data_mem_responder.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types, access-size codes and fault check for data-side memory responders
package dmem_pkg;

    localparam logic [1:0] AREA_BYTE = 2'b00;
    localparam logic [1:0] AREA_HALF = 2'b01;
    localparam logic [1:0] AREA_WORD = 2'b10;
    localparam logic [1:0] AREA_RSVD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    // Addresses below base wrap to a huge word offset and therefore fault as out of range.
    function automatic logic is_fault(input logic [1:0] area, input logic [31:0] addr,
                                      input logic [31:0] base, input int unsigned depth);
        logic [31:0] word_off;
        logic        bad;
        word_off = (addr - base) >> 2;
        bad      = 1'b0;
        case (area)
            AREA_HALF: bad = addr[0];
            AREA_WORD: bad = (addr[1:0] != 2'b00);
            AREA_RSVD: bad = 1'b1;
            default:   bad = 1'b0;
        endcase
        if (word_off >= depth) bad = 1'b1;
        return bad;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - little-endian lane steering for stores and load extraction/extension
module mem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  offset,
    input  logic [1:0]  area,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  byte_en,
    output logic [31:0] wlane,
    output logic [31:0] rdata
);

    logic [31:0] shifted;

    always_comb begin
        byte_en = 4'b0000;
        wlane   = wdata;
        shifted = rword >> {offset, 3'b000};
        rdata   = '0;
        case (area)
            AREA_BYTE: begin
                byte_en = 4'b0001 << offset;
                wlane   = {4{wdata[7:0]}};
                rdata   = {{24{~is_unsigned & shifted[7]}}, shifted[7:0]};
            end
            AREA_HALF: begin
                byte_en = offset[1] ? 4'b1100 : 4'b0011;
                wlane   = {2{wdata[15:0]}};
                rdata   = {{16{~is_unsigned & shifted[15]}}, shifted[15:0]};
            end
            AREA_WORD: begin
                byte_en = 4'b1111;
                wlane   = wdata;
                rdata   = rword;
            end
            default: begin
                byte_en = 4'b0000;
                rdata   = '0;
            end
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - single-outstanding load/store responder with wait states over word RAM
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_area,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    state_t      state, next_state;
    logic [3:0]  cnt;
    logic        cap_write, cap_unsigned;
    logic [1:0]  cap_area;
    logic [31:0] cap_addr, cap_wdata;
    logic        accept, fault, commit;
    logic        cur_write, cur_unsigned;
    logic [1:0]  cur_area;
    logic [31:0] cur_addr, cur_wdata;
    logic [IDX_W-1:0] idx;
    logic [3:0]  byte_en;
    logic [31:0] wlane, rword, load_data;
    logic [31:0] mem [DEPTH_WORDS];

    assign req_ready = (state == ST_IDLE) && reset;
    assign rsp_valid = (state == ST_RESP);
    assign accept    = req_valid && req_ready;
    assign fault     = is_fault(req_area, req_addr, BASE_ADDR, DEPTH_WORDS);

    // A zero-wait commit happens on the accept edge, before the capture registers load.
    assign cur_write    = (state == ST_IDLE) ? req_write    : cap_write;
    assign cur_area     = (state == ST_IDLE) ? req_area     : cap_area;
    assign cur_unsigned = (state == ST_IDLE) ? req_unsigned : cap_unsigned;
    assign cur_addr     = (state == ST_IDLE) ? req_addr     : cap_addr;
    assign cur_wdata    = (state == ST_IDLE) ? req_wdata    : cap_wdata;

    assign idx   = IDX_W'((cur_addr - BASE_ADDR) >> 2);
    assign rword = mem[idx];

    mem_lane_align u_align (
        .offset      (cur_addr[1:0]),
        .area        (cur_area),
        .is_unsigned (cur_unsigned),
        .wdata       (cur_wdata),
        .rword       (rword),
        .byte_en     (byte_en),
        .wlane       (wlane),
        .rdata       (load_data)
    );

    always_ff @(posedge clk) begin
        if (!reset) state <= ST_IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        commit     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (fault) begin
                        next_state = ST_RESP;
                    end else if (WAIT_STATES == 0) begin
                        commit     = 1'b1;
                        next_state = ST_RESP;
                    end else begin
                        next_state = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt == 4'd1) begin
                    commit     = 1'b1;
                    next_state = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt          <= 4'd0;
            rsp_rdata    <= '0;
            rsp_error    <= 1'b0;
            cap_write    <= 1'b0;
            cap_area     <= AREA_BYTE;
            cap_unsigned <= 1'b0;
            cap_addr     <= '0;
            cap_wdata    <= '0;
        end else begin
            if (accept) begin
                cap_write    <= req_write;
                cap_area     <= req_area;
                cap_unsigned <= req_unsigned;
                cap_addr     <= req_addr;
                cap_wdata    <= req_wdata;
                cnt          <= 4'(WAIT_STATES);
                rsp_error    <= fault;
                rsp_rdata    <= '0;
            end else if (state == ST_WAIT) begin
                cnt <= cnt - 4'd1;
            end
            if (commit) begin
                rsp_error <= 1'b0;
                rsp_rdata <= cur_write ? 32'h0 : load_data;
            end
        end
    end

    // RAM is not reset; a commit coinciding with reset low is dropped.
    always_ff @(posedge clk) begin
        if (commit && reset && cur_write) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) mem[idx][8*b +: 8] <= wlane[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - directed self-checking bench for data_mem_responder
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    int          asserts = 0;
    int          failures = 0;

    logic        r2_valid, r2_ready, r2_write, r2_unsigned;
    logic [1:0]  r2_area;
    logic [31:0] r2_addr, r2_wdata;
    logic        s2_valid, s2_ready, s2_error;
    logic [31:0] s2_rdata;

    logic        r0_valid, r0_ready, r0_write, r0_unsigned;
    logic [1:0]  r0_area;
    logic [31:0] r0_addr, r0_wdata;
    logic        s0_valid, s0_ready, s0_error;
    logic [31:0] s0_rdata;

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_STATES(2)) u_w2 (
        .clk(clk), .reset(reset),
        .req_valid(r2_valid), .req_ready(r2_ready), .req_write(r2_write), .req_area(r2_area),
        .req_unsigned(r2_unsigned), .req_addr(r2_addr), .req_wdata(r2_wdata),
        .rsp_valid(s2_valid), .rsp_ready(s2_ready), .rsp_rdata(s2_rdata), .rsp_error(s2_error)
    );

    data_mem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_STATES(0)) u_w0 (
        .clk(clk), .reset(reset),
        .req_valid(r0_valid), .req_ready(r0_ready), .req_write(r0_write), .req_area(r0_area),
        .req_unsigned(r0_unsigned), .req_addr(r0_addr), .req_wdata(r0_wdata),
        .rsp_valid(s0_valid), .rsp_ready(s0_ready), .rsp_rdata(s0_rdata), .rsp_error(s0_error)
    );

    // Latency is the number of edges from the accept edge (counted as 1) until rsp_valid is seen.
    task automatic txn2(input logic wr, input logic [1:0] area, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat);
        r2_write = wr; r2_area = area; r2_unsigned = uns; r2_addr = addr; r2_wdata = wd;
        r2_valid = 1'b1; s2_ready = 1'b1; lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            r2_valid = 1'b0;
            if (s2_valid) begin
                lat = i;
                break;
            end
        end
        rd = s2_rdata; er = s2_error;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        asserts++; if (r2_ready !== 1'b0) begin failures++; $display("FAIL reset_req_ready got %b expected 0", r2_ready); end
        asserts++; if (s2_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got %b expected 0", s2_valid); end
        asserts++; if (s2_rdata !== 32'h0) begin failures++; $display("FAIL reset_rsp_rdata got %h expected 0", s2_rdata); end
        asserts++; if (s2_error !== 1'b0) begin failures++; $display("FAIL reset_rsp_error got %b expected 0", s2_error); end
        asserts++; if (r0_ready !== 1'b0) begin failures++; $display("FAIL reset_req_ready_w0 got %b expected 0", r0_ready); end
        reset = 1'b1;
        @(posedge clk); #1;
        asserts++; if (r2_ready !== 1'b1) begin failures++; $display("FAIL release_req_ready got %b expected 1", r2_ready); end
        asserts++; if (r0_ready !== 1'b1) begin failures++; $display("FAIL release_req_ready_w0 got %b expected 1", r0_ready); end
    endtask

    task automatic test_word();
        logic [31:0] rd; logic er; int lat;
        txn2(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, rd, er, lat);
        asserts++; if (lat !== 3) begin failures++; $display("FAIL store_latency got %0d expected 3", lat); end
        asserts++; if (er !== 1'b0) begin failures++; $display("FAIL store_error got %b expected 0", er); end
        asserts++; if (rd !== 32'h0) begin failures++; $display("FAIL store_rdata got %h expected 0", rd); end
        txn2(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, er, lat);
        asserts++; if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL word_load got %h expected deadbeef", rd); end
        asserts++; if (lat !== 3) begin failures++; $display("FAIL load_latency got %0d expected 3", lat); end
    endtask

    task automatic test_subword();
        logic [31:0] rd; logic er; int lat;
        txn2(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, rd, er, lat);
        asserts++; if (rd !== 32'hFFFFFFDE) begin failures++; $display("FAIL byte_signed got %h expected ffffffde", rd); end
        txn2(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, rd, er, lat);
        asserts++; if (rd !== 32'h000000DE) begin failures++; $display("FAIL byte_unsigned got %h expected 000000de", rd); end
        txn2(1'b1, 2'b01, 1'b0, 32'h12, 32'hAAAA1234, rd, er, lat);
        asserts++; if (er !== 1'b0) begin failures++; $display("FAIL half_store_error got %b expected 0", er); end
        txn2(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, er, lat);
        asserts++; if (rd !== 32'h1234BEEF) begin failures++; $display("FAIL half_merge got %h expected 1234beef", rd); end
        txn2(1'b0, 2'b01, 1'b0, 32'h10, 32'h0, rd, er, lat);
        asserts++; if (rd !== 32'hFFFFBEEF) begin failures++; $display("FAIL half_signed got %h expected ffffbeef", rd); end
    endtask

    task automatic test_faults();
        logic [31:0] rd; logic er; int lat;
        logic        fw   [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [1:0]  fa   [5] = '{2'b01, 2'b10, 2'b11, 2'b10, 2'b10};
        logic [31:0] fadr [5] = '{32'h11, 32'h12, 32'h10, 32'h1000, 32'h1010};
        for (int k = 0; k < 5; k++) begin
            txn2(fw[k], fa[k], 1'b0, fadr[k], 32'h5555_5555, rd, er, lat);
            asserts++; if (er !== 1'b1) begin failures++; $display("FAIL fault%0d_error got %b expected 1", k, er); end
            asserts++; if (rd !== 32'h0) begin failures++; $display("FAIL fault%0d_rdata got %h expected 0", k, rd); end
            asserts++; if (lat !== 1) begin failures++; $display("FAIL fault%0d_latency got %0d expected 1", k, lat); end
        end
        txn2(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, er, lat);
        asserts++; if (rd !== 32'h1234BEEF) begin failures++; $display("FAIL fault_reread got %h expected 1234beef", rd); end
    endtask

    task automatic test_backpressure();
        logic [31:0] rd; logic er; int lat; logic seen;
        r2_write = 1'b0; r2_area = 2'b10; r2_unsigned = 1'b0; r2_addr = 32'h10; r2_wdata = 32'h0;
        r2_valid = 1'b1; s2_ready = 1'b0; seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk); #1;
            r2_valid = 1'b0;
            seen = s2_valid;
        end
        asserts++; if (seen !== 1'b1) begin failures++; $display("FAIL bp_response got %b expected 1", seen); end
        r2_write = 1'b1; r2_addr = 32'h10; r2_wdata = 32'h0; r2_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            asserts++; if (s2_valid !== 1'b1 || s2_rdata !== 32'h1234BEEF || s2_error !== 1'b0 || r2_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold%0d got valid=%b rdata=%h error=%b req_ready=%b expected 1 1234beef 0 0",
                         i, s2_valid, s2_rdata, s2_error, r2_ready);
            end
        end
        r2_valid = 1'b0; s2_ready = 1'b1;
        @(posedge clk); #1;
        asserts++; if (r2_ready !== 1'b1 || s2_valid !== 1'b0) begin
            failures++; $display("FAIL bp_release got req_ready=%b rsp_valid=%b expected 1 0", r2_ready, s2_valid);
        end
        txn2(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, er, lat);
        asserts++; if (rd !== 32'h1234BEEF) begin failures++; $display("FAIL bp_no_second_accept got %h expected 1234beef", rd); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic er; int lat;
        txn2(1'b1, 2'b10, 1'b0, 32'h20, 32'h11112222, rd, er, lat);
        r2_write = 1'b1; r2_area = 2'b10; r2_addr = 32'h20; r2_wdata = 32'hCAFEF00D; r2_valid = 1'b1;
        @(posedge clk); #1;
        r2_valid = 1'b0;
        reset = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        asserts++; if (r2_ready !== 1'b0 || s2_valid !== 1'b0 || s2_rdata !== 32'h0 || s2_error !== 1'b0) begin
            failures++; $display("FAIL midreset_outputs got ready=%b valid=%b rdata=%h error=%b expected 0 0 0 0",
                                 r2_ready, s2_valid, s2_rdata, s2_error);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        asserts++; if (r2_ready !== 1'b1) begin failures++; $display("FAIL midreset_ready got %b expected 1", r2_ready); end
        txn2(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, rd, er, lat);
        asserts++; if (rd !== 32'h11112222) begin failures++; $display("FAIL midreset_dropped got %h expected 11112222", rd); end
    endtask

    task automatic test_back_to_back();
        logic        bw [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [1:0]  ba [8] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b01, 2'b00, 2'b00};
        logic        bu [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [31:0] bad [8] = '{32'h40, 32'h40, 32'h44, 32'h44, 32'h4A, 32'h4A, 32'h4F, 32'h4F};
        logic [31:0] bwd [8] = '{32'h01234567, 32'h0, 32'h89ABCDEF, 32'h0, 32'h0000BEEF, 32'h0, 32'h00000080, 32'h0};
        logic [31:0] bex [8] = '{32'h0, 32'h01234567, 32'h0, 32'h89ABCDEF, 32'h0, 32'h0000BEEF, 32'h0, 32'hFFFFFF80};
        s0_ready = 1'b1;
        r0_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            r0_write = bw[k]; r0_area = ba[k]; r0_unsigned = bu[k]; r0_addr = bad[k]; r0_wdata = bwd[k];
            @(posedge clk); #1;
            asserts++; if (s0_valid !== 1'b1 || s0_rdata !== bex[k] || s0_error !== 1'b0) begin
                failures++; $display("FAIL b2b%0d_rsp got valid=%b rdata=%h error=%b expected 1 %h 0",
                                     k, s0_valid, s0_rdata, s0_error, bex[k]);
            end
            @(posedge clk); #1;
            asserts++; if (r0_ready !== 1'b1 || s0_valid !== 1'b0) begin
                failures++; $display("FAIL b2b%0d_idle got req_ready=%b rsp_valid=%b expected 1 0", k, r0_ready, s0_valid);
            end
        end
        r0_valid = 1'b0;
    endtask

    initial begin
        r2_valid = 0; r2_write = 0; r2_area = 0; r2_unsigned = 0; r2_addr = 0; r2_wdata = 0; s2_ready = 0;
        r0_valid = 0; r0_write = 0; r0_area = 0; r0_unsigned = 0; r0_addr = 0; r0_wdata = 0; s0_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_word();
        test_subword();
        test_faults();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

endmodule
